vec_load: RTL and testbench

- Producer side of the vector datapath: fetches VEC_SIZE fixpoint elements from a word-serial memory read port at base + i*stride.
- Assembles them into one packed vector.
- Hands the vector to the vector arithmetic unit over a valid/ready handshake.
- Sits between the load/store memory port and the vector operand registers.

---
 rtl/vec_pkg.sv | 14 +
 rtl/vec_load.sv | 127 ++++++++++++
 tb/tb_vec_load.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/vec_pkg.sv
// Shared types for the vector load path: element type and load FSM states.
package vec_pkg;

    localparam int FIXPOINT_WIDTH = 16;

    typedef logic [FIXPOINT_WIDTH-1:0] fix_t;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DONE
    } vec_load_state_e;

endpackage

// File: rtl/vec_load.sv
// Strided vector fetch: issues word reads at base + i*stride, packs responses into one vector.
// Optional VEC_LOAD_LEN_EN adds i_len to load only the first min(i_len, VEC_SIZE) elements.
module vec_load
    import vec_pkg::*;
#(
    parameter int VEC_SIZE     = 16,
    parameter int ADDR_WIDTH   = 32,
    parameter int STRIDE_WIDTH = 16
) (
    input  logic                             i_clk,
    input  logic                             i_rst,
    input  logic                             i_start,
    input  logic [ADDR_WIDTH-1:0]            i_base_addr,
    input  logic [STRIDE_WIDTH-1:0]          i_stride,
`ifdef VEC_LOAD_LEN_EN
    input  logic [$clog2(VEC_SIZE):0]        i_len,
`endif
    output logic                             o_busy,
    output logic                             o_mem_req,
    output logic [ADDR_WIDTH-1:0]            o_mem_addr,
    input  logic                             i_mem_gnt,
    input  logic                             i_mem_rvalid,
    input  fix_t                             i_mem_rdata,
    output fix_t [VEC_SIZE-1:0]              o_vec,
    output logic                             o_vec_valid,
    input  logic                             i_vec_ready
);

    localparam int CNT_W = $clog2(VEC_SIZE) + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(VEC_SIZE);

    typedef fix_t [VEC_SIZE-1:0] vec_t;

    vec_load_state_e           state_q, state_d;
    logic [ADDR_WIDTH-1:0]     addr_q, addr_d;
    logic [STRIDE_WIDTH-1:0]   stride_q, stride_d;
    logic [CNT_W-1:0]          issue_cnt_q, issue_cnt_d;
    logic [CNT_W-1:0]          recv_cnt_q, recv_cnt_d;
    logic [CNT_W-1:0]          target_q, target_d;
    vec_t                      vec_q, vec_d;

    logic issue;
    logic recv;

    assign issue = o_mem_req & i_mem_gnt;
    // Responses only count while fetching and before the vector is full.
    assign recv  = (state_q == FETCH) && i_mem_rvalid && (recv_cnt_q < target_q);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (i_start) state_d = FETCH;
            FETCH:   if (recv_cnt_d == target_q) state_d = DONE;
            DONE:    if (i_vec_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        o_busy      = (state_q != IDLE);
        o_mem_req   = (state_q == FETCH) && (issue_cnt_q < target_q);
        o_vec_valid = (state_q == DONE);
    end

    assign o_mem_addr = addr_q;
    assign o_vec      = vec_q;

    always_comb begin
        addr_d      = addr_q;
        stride_d    = stride_q;
        issue_cnt_d = issue_cnt_q;
        recv_cnt_d  = recv_cnt_q;
        target_d    = target_q;
        vec_d       = vec_q;
        if (state_q == IDLE && i_start) begin
            addr_d      = i_base_addr;
            stride_d    = i_stride;
            issue_cnt_d = '0;
            recv_cnt_d  = '0;
`ifdef VEC_LOAD_LEN_EN
            target_d    = (i_len > FULL) ? FULL : i_len;
            vec_d       = '0;
`else
            target_d    = FULL;
`endif
        end else begin
            if (issue) begin
                issue_cnt_d = issue_cnt_q + 1'b1;
                addr_d      = addr_q + ADDR_WIDTH'(stride_q);
            end
            if (recv) begin
                vec_d[recv_cnt_q[CNT_W-2:0]] = i_mem_rdata;
                recv_cnt_d                   = recv_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        // NOTE: the vector storage is reset too, since o_vec must read all-zero after reset.
        if (i_rst) begin
            addr_q      <= '0;
            stride_q    <= '0;
            issue_cnt_q <= '0;
            recv_cnt_q  <= '0;
            target_q    <= '0;
            vec_q       <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments only.
            addr_q      <= addr_d;
            stride_q    <= stride_d;
            issue_cnt_q <= issue_cnt_d;
            recv_cnt_q  <= recv_cnt_d;
            target_q    <= target_d;
            vec_q       <= vec_d;
        end
    end

endmodule

// File: tb/tb_vec_load.sv
// Self-checking bench for vec_load: randomized memory stalls/latency against an address/data model.
module tb_vec_load;
    import vec_pkg::*;

    localparam int VS = 16;
    localparam int AW = 32;
    localparam int SW = 16;
    localparam int FW = FIXPOINT_WIDTH;
    localparam int CW = $clog2(VS) + 1;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  start;
    logic [AW-1:0]         base_addr;
    logic [SW-1:0]         stride;
`ifdef VEC_LOAD_LEN_EN
    logic [CW-1:0]         len;
`endif
    logic                  busy;
    logic                  mem_req;
    logic [AW-1:0]         mem_addr;
    logic                  mem_gnt;
    logic                  mem_rvalid;
    fix_t                  mem_rdata;
    fix_t [VS-1:0]         vec;
    logic                  vec_valid;
    logic                  vec_ready;

    always #5 clk = ~clk;

    vec_load #(.VEC_SIZE(VS), .ADDR_WIDTH(AW), .STRIDE_WIDTH(SW)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_start      (start),
        .i_base_addr  (base_addr),
        .i_stride     (stride),
`ifdef VEC_LOAD_LEN_EN
        .i_len        (len),
`endif
        .o_busy       (busy),
        .o_mem_req    (mem_req),
        .o_mem_addr   (mem_addr),
        .i_mem_gnt    (mem_gnt),
        .i_mem_rvalid (mem_rvalid),
        .i_mem_rdata  (mem_rdata),
        .o_vec        (vec),
        .o_vec_valid  (vec_valid),
        .i_vec_ready  (vec_ready)
    );

    int checks = 0;
    int errors = 0;
    int cycle  = 0;
    int t0     = 0;

    // Reference model of one load: expected addresses, data to return, resulting vector.
    logic [AW-1:0]          exp_addr [VS];
    logic [FW-1:0]          data     [VS];
    logic [VS-1:0][FW-1:0]  exp_vec;
    int                     due_q[$];
    int                     last_due;
    int                     issued;
    int                     sent;
    int                     n_exp;
    bit                     stall;
    bit                     stray;

    task automatic check(input string tag, input logic [VS*FW-1:0] got, input logic [VS*FW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cycle);
        end
    endtask

    task automatic prep(input logic [AW-1:0] base, input logic [SW-1:0] str, input int n, input bit seq);
        n_exp = (n < VS) ? n : VS;
        for (int i = 0; i < VS; i++) begin
            exp_addr[i] = base + AW'(i) * AW'(str);
            data[i]     = seq ? FW'(i + 1) : FW'($urandom);
            exp_vec[i]  = (i < n_exp) ? data[i] : '0;
        end
        issued   = 0;
        sent     = 0;
        last_due = cycle;
        due_q.delete();
    endtask

    // One clock of memory behaviour; called at posedge+1, returns at the next posedge+1.
    task automatic mem_cycle();
        logic g;
        int   lat;
        int   due;
        g       = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
        lat     = stall ? int'($urandom_range(1, 5)) : 1;
        mem_gnt = g;
        if (issued >= n_exp)
            check("no_req_after_last", mem_req, 1'b0);
        if (mem_req && g && issued < n_exp) begin
            check("addr", mem_addr, exp_addr[issued]);
            due = cycle + lat;
            if (due <= last_due) due = last_due + 1;
            due_q.push_back(due);
            last_due = due;
            issued++;
        end
        if (due_q.size() > 0 && due_q[0] == cycle) begin
            mem_rvalid = 1'b1;
            mem_rdata  = data[sent];
            sent++;
            void'(due_q.pop_front());
        end else begin
            mem_rvalid = stray;
            mem_rdata  = FW'($urandom);
        end
        @(posedge clk);
        #1;
        cycle++;
    endtask

    task automatic start_load(input logic [AW-1:0] base, input logic [SW-1:0] str, input int n);
        base_addr = base;
        stride    = str;
`ifdef VEC_LOAD_LEN_EN
        len       = CW'(n);
`endif
        start     = 1'b1;
        t0        = cycle;
        mem_cycle();
        start     = 1'b0;
        base_addr = AW'($urandom);
        stride    = SW'($urandom);
    endtask

    task automatic wait_valid();
        for (int k = 0; k < 400 && !vec_valid; k++) mem_cycle();
        check("valid_seen", vec_valid, 1'b1);
        if (!stall) check("latency", cycle - t0, n_exp + 2);
        check("issued_count", issued, n_exp);
        check("busy_in_done", busy, 1'b1);
        check("vec", vec, exp_vec);
    endtask

    // Hold ready low for `hold` cycles (optionally poking start and stray rvalid), then handshake.
    task automatic finish_load(input int hold, input bit poke);
        logic [VS-1:0][FW-1:0] snap;
        snap      = vec;
        vec_ready = 1'b0;
        stray     = poke;
        for (int i = 0; i < hold; i++) begin
            start     = poke;
            base_addr = AW'($urandom);
            mem_cycle();
            check("hold_valid", vec_valid, 1'b1);
            check("hold_vec", vec, snap);
            check("hold_no_req", mem_req, 1'b0);
        end
        vec_ready = 1'b1;
        start     = poke;
        mem_cycle();
        start = 1'b0;
        stray = 1'b0;
        check("post_valid", vec_valid, 1'b0);
        check("post_busy", busy, 1'b0);
        check("post_vec", vec, snap);
    endtask

    task automatic full_load(input logic [AW-1:0] base, input logic [SW-1:0] str, input int n,
                             input bit seq, input int hold, input bit poke);
        prep(base, str, n, seq);
        start_load(base, str, n);
        wait_valid();
        finish_load(hold, poke);
    endtask

    initial begin
        logic [VS-1:0][FW-1:0] snap;
        rst        = 1'b1;
        start      = 1'b0;
        base_addr  = '0;
        stride     = '0;
`ifdef VEC_LOAD_LEN_EN
        len        = '0;
`endif
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        vec_ready  = 1'b1;
        stall      = 1'b0;
        stray      = 1'b0;
        n_exp      = 0;
        issued     = 0;
        sent       = 0;
        last_due   = 0;
        repeat (3) begin
            @(posedge clk);
            #1;
            cycle++;
        end
        check("rst_busy", busy, 1'b0);
        check("rst_req", mem_req, 1'b0);
        check("rst_valid", vec_valid, 1'b0);
        check("rst_addr", mem_addr, '0);
        check("rst_vec", vec, '0);
        rst = 1'b0;
        mem_cycle();

        // Directed sequential load with fixed 1-cycle latency.
        stall = 1'b0;
        full_load(32'h0000_0100, 16'd4, VS, 1'b1, 0, 1'b0);

        // Stray rvalid in IDLE must not disturb the held vector.
        snap  = vec;
        stray = 1'b1;
        repeat (3) mem_cycle();
        stray = 1'b0;
        check("idle_stray_vec", vec, snap);
        check("idle_busy", busy, 1'b0);

        // Random stalls and latencies.
        stall = 1'b1;
        for (int r = 0; r < 5; r++)
            full_load(AW'($urandom), SW'($urandom), VS, 1'b0, int'($urandom_range(0, 3)), 1'b1);

        // Address wrap.
        stall = 1'b0;
        full_load(32'hFFFF_FFF8, 16'd4, VS, 1'b0, 0, 1'b0);

        // Long back-pressure with start and stray rvalid pokes.
        full_load(32'h0000_2000, 16'd2, VS, 1'b0, 10, 1'b1);

        // Reset after five grants.
        prep(32'h0000_0400, 16'd8, VS, 1'b1);
        start_load(32'h0000_0400, 16'd8, VS);
        for (int k = 0; k < 50 && issued < 5; k++) mem_cycle();
        check("five_grants", issued, 5);
        check("partial_vec_loaded", (vec != '0), 1'b1);
        rst = 1'b1;
        mem_cycle();
        rst = 1'b0;
        due_q.delete();
        n_exp = 0;
        check("midrst_busy", busy, 1'b0);
        check("midrst_req", mem_req, 1'b0);
        check("midrst_valid", vec_valid, 1'b0);
        check("midrst_vec", vec, '0);
        full_load(32'h0000_0800, 16'd12, VS, 1'b0, 1, 1'b0);
        stall = 1'b1;
        full_load(AW'($urandom), SW'($urandom), VS, 1'b0, 2, 1'b1);

`ifdef VEC_LOAD_LEN_EN
        stall = 1'b0;
        full_load(32'h0000_3000, 16'd4, 3, 1'b0, 0, 1'b0);
        full_load(32'h0000_3100, 16'd4, 0, 1'b0, 0, 1'b0);
        full_load(32'h0000_3200, 16'd4, 2 * VS - 1, 1'b0, 0, 1'b0);
        stall = 1'b1;
        for (int r = 0; r < 3; r++)
            full_load(AW'($urandom), SW'($urandom), int'($urandom_range(0, 2 * VS - 1)), 1'b0, 1, 1'b1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
